// File: rtl/ex_mem_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_buffer_if
// Description : EX/MEM buffer bus: EX-stage inputs, registered MEM-stage
//               outputs, redirect request and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_buffer_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              RegWrite;
    logic              MemtoReg;
    logic              MemRead;
    logic              MemWrite;
    logic              Branch;
    logic              Jump;
    logic [DATA_W-1:0] ALU;
    logic              Zero;
    logic [DATA_W-1:0] WriteData_in;
    logic [REG_W-1:0]  WriteReg_in;
    logic [DATA_W-1:0] BranchTarget;
    logic [DATA_W-1:0] JumpTarget;

    logic              valid_q;
    logic              RegWrite_q;
    logic              MemtoReg_q;
    logic              MemRead_q;
    logic              MemWrite_q;
    logic [DATA_W-1:0] ALU_q;
    logic [DATA_W-1:0] WriteData_q;
    logic [REG_W-1:0]  WriteReg_q;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
    logic [31:0]       stall_cnt;
    logic [31:0]       squash_cnt;

    modport master (
        output stall, flush, in_valid, RegWrite, MemtoReg, MemRead, MemWrite,
               Branch, Jump, ALU, Zero, WriteData_in, WriteReg_in,
               BranchTarget, JumpTarget,
        input  valid_q, RegWrite_q, MemtoReg_q, MemRead_q, MemWrite_q,
               ALU_q, WriteData_q, WriteReg_q, redirect, redirect_pc,
               stall_cnt, squash_cnt
    );

    modport slave (
        input  stall, flush, in_valid, RegWrite, MemtoReg, MemRead, MemWrite,
               Branch, Jump, ALU, Zero, WriteData_in, WriteReg_in,
               BranchTarget, JumpTarget,
        output valid_q, RegWrite_q, MemtoReg_q, MemRead_q, MemWrite_q,
               ALU_q, WriteData_q, WriteReg_q, redirect, redirect_pc,
               stall_cnt, squash_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_buffer
// Description : EX/MEM pipeline register with branch/jump redirect, stall and
//               flush. Optional counters enabled by EXMEM_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  wire              clk,
    input  wire              rst,
    ex_mem_buffer_if.slave   bus
);
    logic              r_valid;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_jump;
    logic              r_taken;
    logic              r_fired;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_W-1:0]  r_wreg;
    logic [DATA_W-1:0] r_btarget;
    logic [DATA_W-1:0] r_jtarget;

    logic              w_redirect;
    logic              w_bubble;

    assign w_redirect = r_valid & r_taken & ~r_fired;
    // A redirect that is not held by stall means the incoming EX instruction
    // is on the wrong path, so it is dropped just like a flush.
    assign w_bubble   = rst | bus.flush | (~bus.stall & w_redirect);

    always_ff @(posedge clk) begin
        if (w_bubble) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_jump     <= 1'b0;
            r_taken    <= 1'b0;
            r_fired    <= 1'b0;
            r_alu      <= '0;
            r_wdata    <= '0;
            r_wreg     <= '0;
            r_btarget  <= '0;
            r_jtarget  <= '0;
        end else if (bus.stall) begin
            if (w_redirect) begin
                r_fired <= 1'b1;
            end
        end else begin
            r_valid    <= bus.in_valid;
            r_regwrite <= bus.in_valid & bus.RegWrite;
            r_memtoreg <= bus.in_valid & bus.MemtoReg;
            r_memread  <= bus.in_valid & bus.MemRead;
            r_memwrite <= bus.in_valid & bus.MemWrite;
            r_jump     <= bus.in_valid & bus.Jump;
            r_taken    <= bus.in_valid & (bus.Jump | (bus.Branch & bus.Zero));
            r_fired    <= 1'b0;
            r_alu      <= bus.ALU;
            r_wdata    <= bus.WriteData_in;
            r_wreg     <= bus.WriteReg_in;
            r_btarget  <= bus.BranchTarget;
            r_jtarget  <= bus.JumpTarget;
        end
    end

    assign bus.valid_q     = r_valid;
    assign bus.RegWrite_q  = r_valid & r_regwrite;
    assign bus.MemtoReg_q  = r_valid & r_memtoreg;
    assign bus.MemRead_q   = r_valid & r_memread;
    assign bus.MemWrite_q  = r_valid & r_memwrite;
    assign bus.ALU_q       = r_alu;
    assign bus.WriteData_q = r_wdata;
    assign bus.WriteReg_q  = r_wreg;
    assign bus.redirect    = w_redirect;
    assign bus.redirect_pc = r_jump ? r_jtarget : r_btarget;

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_squash_cnt;
    logic        w_squash;

    // Flush-discard and wrong-path drop are exclusive by priority, so one
    // increment per cycle at most.
    assign w_squash = (bus.flush & r_valid) |
                      (~bus.flush & ~bus.stall & w_redirect & bus.in_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (bus.stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_squash) begin
                r_squash_cnt <= r_squash_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.squash_cnt = r_squash_cnt;
`else
    assign bus.stall_cnt  = 32'd0;
    assign bus.squash_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_buffer
// Description : Directed-vector scoreboard bench for ex_mem_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_buffer;
    localparam int c_DW = 32;
    localparam int c_RW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_buffer_if #(.DATA_W(c_DW), .REG_W(c_RW)) bus ();

    ex_mem_buffer #(.DATA_W(c_DW), .REG_W(c_RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       nm;
        logic        v;
        logic [3:0]  ctl;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        redir;
        logic [31:0] pc;
        logic [31:0] sc;
        logic [31:0] qc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new registered state every cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.nm, "valid_q",     {31'd0, bus.valid_q}, {31'd0, mon_e.v});
            chk(mon_e.nm, "ctl_q",       {28'd0, bus.RegWrite_q, bus.MemtoReg_q, bus.MemRead_q, bus.MemWrite_q}, {28'd0, mon_e.ctl});
            chk(mon_e.nm, "ALU_q",       bus.ALU_q, mon_e.alu);
            chk(mon_e.nm, "WriteData_q", bus.WriteData_q, mon_e.wd);
            chk(mon_e.nm, "WriteReg_q",  {27'd0, bus.WriteReg_q}, {27'd0, mon_e.wr});
            chk(mon_e.nm, "redirect",    {31'd0, bus.redirect}, {31'd0, mon_e.redir});
            chk(mon_e.nm, "redirect_pc", bus.redirect_pc, mon_e.pc);
            chk(mon_e.nm, "stall_cnt",   bus.stall_cnt, mon_e.sc);
            chk(mon_e.nm, "squash_cnt",  bus.squash_cnt, mon_e.qc);
        end
    end

    // c = {RegWrite, MemtoReg, MemRead, MemWrite, Branch, Jump}
    // ec = {RegWrite_q, MemtoReg_q, MemRead_q, MemWrite_q}
    task automatic vec(input string nm, input logic r, input logic st, input logic fl, input logic iv,
                       input logic [5:0] c, input logic z, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input logic [31:0] bt, input logic [31:0] jt,
                       input logic ev, input logic [3:0] ec, input logic [31:0] ealu, input logic [31:0] ewd,
                       input logic [4:0] ewr, input logic er, input logic [31:0] epc,
                       input logic [31:0] esc, input logic [31:0] eqc);
        exp_t e;
        rst              = r;
        bus.stall        = st;
        bus.flush        = fl;
        bus.in_valid     = iv;
        bus.RegWrite     = c[5];
        bus.MemtoReg     = c[4];
        bus.MemRead      = c[3];
        bus.MemWrite     = c[2];
        bus.Branch       = c[1];
        bus.Jump         = c[0];
        bus.Zero         = z;
        bus.ALU          = alu;
        bus.WriteData_in = wd;
        bus.WriteReg_in  = wr;
        bus.BranchTarget = bt;
        bus.JumpTarget   = jt;
        e.nm = nm; e.v = ev; e.ctl = ec; e.alu = ealu; e.wd = ewd; e.wr = ewr;
        e.redir = er; e.pc = epc; e.sc = esc; e.qc = eqc;
`ifndef EXMEM_PERF_CNT_EN
        e.sc = 32'd0;
        e.qc = 32'd0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with random inputs
        vec("rst0", 1, $urandom_range(1), $urandom_range(1), 1, 6'($urandom_range(63)), 1, $urandom, $urandom, 5'($urandom_range(31)), $urandom, $urandom,
            0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        vec("rst1", 1, 1, 0, 1, 6'($urandom_range(63)), 1, $urandom, $urandom, 5'($urandom_range(31)), $urandom, $urandom,
            0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        vec("pass",     0, 0, 0, 1, 6'b100000, 0, 32'h1234, 32'h55, 5'd5, 32'h8, 32'h0,
            1, 4'b1000, 32'h1234, 32'h55, 5'd5, 0, 32'h8, 0, 0);
        vec("invalid",  0, 0, 0, 0, 6'b000100, 0, 32'h77, 32'h9, 5'd3, 32'h0, 32'h0,
            0, 4'b0000, 32'h77, 32'h9, 5'd3, 0, 32'h0, 0, 0);
        vec("br_taken", 0, 0, 0, 1, 6'b000010, 1, 32'hA, 32'h0, 5'd0, 32'h40, 32'h999,
            1, 4'b0000, 32'hA, 32'h0, 5'd0, 1, 32'h40, 0, 0);
        vec("wrongpath",0, 0, 0, 1, 6'b000100, 0, 32'hB, 32'hC, 5'd7, 32'h10, 32'h0,
            0, 4'b0000, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 1);
        vec("load",     0, 0, 0, 1, 6'b111000, 0, 32'h200, 32'h0, 5'd8, 32'h20, 32'h0,
            1, 4'b1110, 32'h200, 32'h0, 5'd8, 0, 32'h20, 0, 1);
        vec("jmp_br",   0, 0, 0, 1, 6'b100011, 0, 32'h3, 32'h4, 5'd9, 32'h40, 32'h100,
            1, 4'b1000, 32'h3, 32'h4, 5'd9, 1, 32'h100, 0, 1);
        vec("stall1",   0, 1, 0, 1, 6'b000100, 0, 32'hFF, 32'hEE, 5'd31, 32'h4, 32'h8,
            1, 4'b1000, 32'h3, 32'h4, 5'd9, 0, 32'h100, 1, 1);
        vec("stall2",   0, 1, 0, 1, 6'b000100, 0, 32'hFF, 32'hEE, 5'd31, 32'h4, 32'h8,
            1, 4'b1000, 32'h3, 32'h4, 5'd9, 0, 32'h100, 2, 1);
        vec("stall3",   0, 1, 0, 1, 6'b000100, 0, 32'hFF, 32'hEE, 5'd31, 32'h4, 32'h8,
            1, 4'b1000, 32'h3, 32'h4, 5'd9, 0, 32'h100, 3, 1);
        vec("after_st", 0, 0, 0, 1, 6'b100000, 0, 32'h5, 32'h0, 5'd1, 32'h0, 32'h0,
            1, 4'b1000, 32'h5, 32'h0, 5'd1, 0, 32'h0, 3, 1);
        vec("fl_stall", 0, 1, 1, 1, 6'b100000, 0, 32'h6, 32'h0, 5'd2, 32'h0, 32'h0,
            0, 4'b0000, 32'h0, 32'h0, 5'd0, 0, 32'h0, 4, 2);
        vec("br_80",    0, 0, 0, 1, 6'b000010, 1, 32'h0, 32'h0, 5'd0, 32'h80, 32'h0,
            1, 4'b0000, 32'h0, 32'h0, 5'd0, 1, 32'h80, 4, 2);
        vec("rst_mid",  1, 1, 0, 1, 6'b100100, 0, 32'h33, 32'h1, 5'd4, 32'h4, 32'h4,
            0, 4'b0000, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 0);
        vec("flush_e",  0, 0, 1, 1, 6'b100000, 0, 32'h7, 32'h1, 5'd4, 32'h4, 32'h4,
            0, 4'b0000, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 0);
        vec("br_nt",    0, 0, 0, 1, 6'b000110, 0, 32'h10, 32'hAB, 5'd0, 32'h44, 32'h0,
            1, 4'b0001, 32'h10, 32'hAB, 5'd0, 0, 32'h44, 0, 0);
        vec("br_inv",   0, 0, 0, 0, 6'b000010, 1, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0,
            0, 4'b0000, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 0);
        vec("idle",     0, 0, 0, 0, 6'b000000, 0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0,
            0, 4'b0000, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

`ifdef EXMEM_PERF_CNT_EN
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        bus.stall = 1'b1;
        @(posedge clk);
        #1;
        bus.stall = 1'b0;
        chk("wrap", "stall_cnt", bus.stall_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_mem_buffer.md
# ex_mem_buffer

EX/MEM pipeline register of the five-stage MIPS core: captures the execute-stage results and control bits and presents them to the memory stage and the MEM/WB buffer. It also resolves taken branches and jumps, issuing a one-cycle redirect to the PC mux and a squash of younger stages. It supports downstream stall and external flush.

## Interface
- DATA_W, 32, datapath width (ALU result, store data, targets)
- REG_W, 5, register-index width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current contents (downstream not ready)
- flush  in  1  replace contents with a bubble (external exception/flush)
- in_valid  in  1  EX stage holds a real instruction
- RegWrite, MemtoReg, MemRead, MemWrite, Branch, Jump  in  1 each  EX control bits
- ALU  in  DATA_W  ALU result
- Zero  in  1  ALU zero flag
- WriteData_in  in  DATA_W  store data (rt value)
- WriteReg_in  in  REG_W  destination register
- BranchTarget  in  DATA_W  PC+4+(imm<<2)
- JumpTarget  in  DATA_W  jump address
- valid_q  out  1  registered instruction valid
- RegWrite_q, MemtoReg_q, MemRead_q, MemWrite_q  out  1 each  registered control, forced 0 when valid_q=0
- ALU_q, WriteData_q  out  DATA_W  registered data
- WriteReg_q  out  REG_W  registered destination
- redirect  out  1  PC must load redirect_pc this cycle; also squash request to IF/ID/EX
- redirect_pc  out  DATA_W  JumpTarget_q if jump, else BranchTarget_q
- stall_cnt, squash_cnt  out  32  performance counters (see Configuration)

## Operation
- Per-entry state: valid_q, all control/data registers, taken_q = Jump | (Branch & Zero) latched at load, fired_q.
- redirect = valid_q & taken_q & ~fired_q (combinational from registers).
- Update priority each rising edge:
  1. rst: bubble (all outputs 0, fired_q=0).
  2. flush: bubble.
  3. stall: hold all registers; if redirect was high, set fired_q=1.
  4. redirect high and not stall: load bubble (incoming instruction is wrong-path).
  5. otherwise: load inputs; valid_q=in_valid; fired_q=0; control bits gated by in_valid.
- Bubble: valid_q=0, every control bit 0, data/targets/WriteReg 0, taken_q=0, fired_q=0.
- Jump beats Branch when both set: redirect_pc = JumpTarget_q.
- Control outputs never assert with valid_q=0; no memory write or register write from a bubble.

## Timing
- Latency 1 cycle: inputs at edge N appear on *_q after edge N.
- redirect asserts in the first cycle a taken entry is resident, exactly once per entry, even if stalled for many cycles.
- Cycle after redirect (no stall): buffer holds a bubble regardless of in_valid.
- flush and stall together: flush wins.
- rst mid-stall or mid-redirect: next cycle all outputs 0, redirect 0.
- Reset value of every output: 0.

## Configuration
- EXMEM_PERF_CNT_EN defined: stall_cnt increments each cycle stall=1 and rst=0; squash_cnt increments each cycle a wrong-path instruction is dropped (rule 4 with in_valid=1) or flush=1 discards valid_q=1; both 32-bit, wrap at 2^32-1 to 0, cleared by rst.
- Not defined: counters not built; stall_cnt and squash_cnt tied to 0.

## Test plan
- Reset: rst=1 two cycles with random inputs -> all outputs 0, redirect 0.
- Pass-through: in_valid=1, RegWrite=1, ALU=0x0000_1234, WriteReg=5 -> next cycle ALU_q=0x1234, WriteReg_q=5, RegWrite_q=1, redirect=0.
- Taken branch: Branch=1, Zero=1, BranchTarget=0x40 -> redirect=1 with redirect_pc=0x40 for one cycle; following entry (in_valid=1, MemWrite=1) arrives as bubble, MemWrite_q=0; squash_cnt=1 when enabled.
- Jump+Branch while stalled 3 cycles: Jump=1, JumpTarget=0x100, BranchTarget=0x40 -> redirect_pc=0x100, redirect high only in first cycle, contents held; stall_cnt=3 when enabled.
- flush+stall simultaneous with valid entry -> next cycle valid_q=0, all control 0.
- Counter wrap (enabled): preload via forcing stall_cnt=0xFFFF_FFFF, one stall cycle -> 0.
